// File: rtl/labfinalsoc_pkg.sv
// Shared register map and control/status bit positions for the command-out port.
package labfinalsoc_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_PUSH = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DROP = 2'd2;

  // Control register bits (write to ADDR_CTRL)
  localparam int unsigned CTRL_FLUSH    = 0;
  localparam int unsigned CTRL_OVF_CLR  = 1;
  localparam int unsigned CTRL_IRQ_MASK = 2;
  localparam int unsigned CTRL_IRQ_CLR  = 3;

  // Status register bits (read from ADDR_CTRL)
  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  // Saturating 8-bit increment for the drop counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/labfinalsoc_generation_cmd_out_if.sv
// Avalon-MM slave bus plus outbound valid/ready stream of the command-out port.
interface labfinalsoc_generation_cmd_out_if #(
  parameter int unsigned DATA_W = 8
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // CPU/consumer side
  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid
  );

  // Port (DUT) side
  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid
  );
endinterface

// File: rtl/labfinalsoc_sync_fifo.sv
// Synchronous FIFO without fall-through; flush has priority over push and pop.
module labfinalsoc_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers/count; a push while full only lands with a pop
  always_comb begin
    do_pop   = pop_i & ~empty_o & ~flush_i;
    do_push  = push_i & ~flush_i & (~full_o | do_pop);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Storage, pointer and count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/labfinalsoc_generation_cmd_out.sv
// Avalon-MM command-out port: CPU pushes bytes into a FIFO drained by a valid/ready stream.
// Optional drain-complete interrupt built when CMD_OUT_IRQ_EN is defined.
module labfinalsoc_generation_cmd_out
  import labfinalsoc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic reset,
  labfinalsoc_generation_cmd_out_if.slave bus
`ifdef CMD_OUT_IRQ_EN
  ,
  output logic irq
`endif
);
  logic              wr, push_req, flush, ovf_clr, pop, drop;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_q, drop_d;
  logic [31:0]       readdata_q, readdata_d;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign push_req = wr & (bus.address == ADDR_PUSH);
  assign flush    = wr & (bus.address == ADDR_CTRL) & bus.writedata[CTRL_FLUSH];
  assign ovf_clr  = wr & (bus.address == ADDR_CTRL) & bus.writedata[CTRL_OVF_CLR];
  assign pop      = bus.out_valid & bus.out_ready;
  assign drop     = push_req & ~flush & full & ~pop;

  assign bus.out_valid = ~empty;
  assign bus.readdata  = readdata_q;

  labfinalsoc_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (push_req),
    .pop_i  (pop),
    .flush_i(flush),
    .data_i (bus.writedata[DATA_W-1:0]),
    .data_o (bus.out_data),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  // Register read mux, last-pushed byte and sticky overflow/drop accounting
  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      ADDR_PUSH: readdata_d[DATA_W-1:0] = last_q;
      ADDR_CTRL: begin
        readdata_d[STAT_COUNT_LSB +: 8] = 8'(count);
        readdata_d[STAT_OVF]            = ovf_q;
        readdata_d[STAT_FULL]           = full;
        readdata_d[STAT_EMPTY]          = empty;
      end
      ADDR_DROP: readdata_d[7:0] = drop_q;
      default:   readdata_d = '0;
    endcase
    last_d = last_q;
    if (push_req & ~flush & ~drop) last_d = bus.writedata[DATA_W-1:0];
    ovf_d  = ovf_q | drop;
    drop_d = drop ? sat_inc8(drop_q) : drop_q;
    if (ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  // Register-file state
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
      last_q     <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      readdata_q <= readdata_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

`ifdef CMD_OUT_IRQ_EN
  logic irq_q, irq_d, irq_mask_q, irq_mask_d, ctrl_wr;

  assign ctrl_wr = wr & (bus.address == ADDR_CTRL);
  assign irq     = irq_q;

  // Drain-complete: last entry popped (not flushed) while unmasked; clear wins over set
  always_comb begin
    irq_mask_d = ctrl_wr ? bus.writedata[CTRL_IRQ_MASK] : irq_mask_q;
    irq_d      = irq_q;
    if (pop & ~flush & (count == CNT_W'(1)) & irq_mask_q) irq_d = 1'b1;
    if ((ctrl_wr & bus.writedata[CTRL_IRQ_CLR]) | ~irq_mask_q) irq_d = 1'b0;
  end

  // Interrupt and mask registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= 1'b0;
      irq_mask_q <= 1'b0;
    end else begin
      irq_q      <= irq_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[31:DATA_W];
`else
  logic unused_wdata;
  assign unused_wdata = ^{bus.writedata[31:DATA_W], bus.writedata[CTRL_IRQ_CLR],
                          bus.writedata[CTRL_IRQ_MASK]};
`endif

endmodule
